// File: rtl/control_unit.sv
// Processor controller: fetches 16-bit instructions from a registered ROM, decodes them and
// sequences the datapath's memory, mux, register-file and ALU controls.
module control_unit #(
  parameter int unsigned PC_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     I_Data,
  output logic [PC_W-1:0] I_Addr,
  output logic            I_Rd,
  output logic [7:0]      D_Addr,
  output logic            D_WriteEn,
  output logic            MuxS,
  output logic [3:0]      RegF_W_addr,
  output logic            RegF_W_en,
  output logic [3:0]      RegF_Ra_addr,
  output logic [3:0]      RegF_Rb_addr,
  output logic [2:0]      ALU_S,
  output logic            Halt,
  output logic [3:0]      State,
  output logic [PC_W-1:0] PC,
  output logic [15:0]     IR
);

  typedef enum logic [3:0] {
    StInit   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StLoadA  = 4'd3,
    StLoadB  = 4'd4,
    StStore  = 4'd5,
    StAdd    = 4'd6,
    StSub    = 4'd7,
    StNoop   = 4'd8,
    StHalt   = 4'd9
  } state_e;

  localparam logic [PC_W-1:0] PcOne = 1;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  logic       i_rd_d, d_we_d, muxs_d, w_en_d, halt_d;
  logic [7:0] d_addr_d;
  logic [3:0] w_addr_d, ra_d, rb_d;
  logic [2:0] alu_s_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      StInit:   state_d = StFetch;
      StFetch: begin
        pc_d    = pc_q + PcOne;
        state_d = StDecode;
      end
      StDecode: begin
        ir_d = I_Data;
        case (I_Data[15:12])
          4'h1:    state_d = StStore;
          4'h2:    state_d = StLoadA;
          4'h3:    state_d = StAdd;
          4'h4:    state_d = StSub;
          4'h5:    state_d = StHalt;
          default: state_d = StNoop;
        endcase
      end
      StLoadA:  state_d = StLoadB;
      StLoadB, StStore, StAdd, StSub, StNoop: state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StInit;
    endcase
  end

  // Outputs are decoded from the upcoming state so that they appear registered yet Moore-aligned.
  always_comb begin
    i_rd_d   = 1'b0;
    d_we_d   = 1'b0;
    muxs_d   = 1'b0;
    w_en_d   = 1'b0;
    halt_d   = 1'b0;
    d_addr_d = 8'h00;
    w_addr_d = 4'h0;
    ra_d     = 4'h0;
    rb_d     = 4'h0;
    alu_s_d  = 3'd0;
    case (state_d)
      StFetch: i_rd_d = 1'b1;
      StLoadA: begin
        d_addr_d = ir_d[11:4];
        muxs_d   = 1'b1;
      end
      StLoadB: begin
        d_addr_d = ir_d[11:4];
        muxs_d   = 1'b1;
        w_addr_d = ir_d[3:0];
        w_en_d   = 1'b1;
      end
      StStore: begin
        d_addr_d = ir_d[11:4];
        ra_d     = ir_d[3:0];
        d_we_d   = 1'b1;
      end
      StAdd, StSub: begin
        ra_d     = ir_d[11:8];
        rb_d     = ir_d[7:4];
        w_addr_d = ir_d[3:0];
        w_en_d   = 1'b1;
        alu_s_d  = (state_d == StAdd) ? 3'd1 : 3'd2;
      end
      StHalt:  halt_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StInit;
      pc_q         <= '0;
      ir_q         <= 16'h0000;
      I_Rd         <= 1'b0;
      D_WriteEn    <= 1'b0;
      MuxS         <= 1'b0;
      RegF_W_en    <= 1'b0;
      Halt         <= 1'b0;
      D_Addr       <= 8'h00;
      RegF_W_addr  <= 4'h0;
      RegF_Ra_addr <= 4'h0;
      RegF_Rb_addr <= 4'h0;
      ALU_S        <= 3'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      I_Rd         <= i_rd_d;
      D_WriteEn    <= d_we_d;
      MuxS         <= muxs_d;
      RegF_W_en    <= w_en_d;
      Halt         <= halt_d;
      D_Addr       <= d_addr_d;
      RegF_W_addr  <= w_addr_d;
      RegF_Ra_addr <= ra_d;
      RegF_Rb_addr <= rb_d;
      ALU_S        <= alu_s_d;
    end
  end

  assign State  = state_q;
  assign PC     = pc_q;
  assign I_Addr = pc_q;
  assign IR     = ir_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a short program through a PC_W=7 instance plus a PC_W=2
// instance running all-NOOP code to exercise PC wrap.
module tb_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance
  logic        rst_n;
  logic [15:0] i_data;
  logic [6:0]  i_addr, pc;
  logic        i_rd, d_we, muxs, w_en, halt;
  logic [7:0]  d_addr;
  logic [3:0]  w_addr, ra, rb, state;
  logic [2:0]  alu_s;
  logic [15:0] ir;
  logic [15:0] rom [0:127];

  always @(posedge clk) i_data <= rom[i_addr];

  control_unit #(.PC_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .I_Data(i_data), .I_Addr(i_addr), .I_Rd(i_rd),
    .D_Addr(d_addr), .D_WriteEn(d_we), .MuxS(muxs), .RegF_W_addr(w_addr),
    .RegF_W_en(w_en), .RegF_Ra_addr(ra), .RegF_Rb_addr(rb), .ALU_S(alu_s),
    .Halt(halt), .State(state), .PC(pc), .IR(ir)
  );

  // Small instance, ROM of all zeros (NOOP)
  logic        rst2_n;
  logic [15:0] i_data2;
  logic [1:0]  i_addr2, pc2;
  logic        i_rd2, d_we2, muxs2, w_en2, halt2;
  logic [7:0]  d_addr2;
  logic [3:0]  w_addr2, ra2, rb2, state2;
  logic [2:0]  alu_s2;
  logic [15:0] ir2;

  always @(posedge clk) i_data2 <= 16'h0000;

  control_unit #(.PC_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .I_Data(i_data2), .I_Addr(i_addr2), .I_Rd(i_rd2),
    .D_Addr(d_addr2), .D_WriteEn(d_we2), .MuxS(muxs2), .RegF_W_addr(w_addr2),
    .RegF_W_en(w_en2), .RegF_Ra_addr(ra2), .RegF_Rb_addr(rb2), .ALU_S(alu_s2),
    .Halt(halt2), .State(state2), .PC(pc2), .IR(ir2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed enables: {I_Rd, D_WriteEn, MuxS, RegF_W_en, Halt}
  function automatic logic [4:0] ens();
    return {i_rd, d_we, muxs, w_en, halt};
  endfunction

  initial begin
    logic [1:0] exp_pc;
    bit         found;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h2013;
    rom[1] = 16'h3125;
    rom[2] = 16'h4426;
    rom[3] = 16'h1055;
    rom[4] = 16'hF000;
    rom[5] = 16'h5000;
    rst_n  = 1'b0;
    rst2_n = 1'b0;

    repeat (2) step();
    chk("rst_state", state, 4'd0);
    chk("rst_pc", pc, 7'd0);
    chk("rst_ir", ir, 16'h0);
    chk("rst_ens", ens(), 5'b00000);
    #2 rst_n = 1'b1;
    #1 chk("init_state", state, 4'd0);

    step();
    chk("fetch_state", state, 4'd1);
    chk("fetch_pc", i_addr, 7'd0);
    chk("fetch_ens", ens(), 5'b10000);
    step();
    chk("decode_state", state, 4'd2);
    chk("decode_pc", pc, 7'd1);
    chk("decode_ens", ens(), 5'b00000);
    step();
    chk("loada_state", state, 4'd3);
    chk("loada_ir", ir, 16'h2013);
    chk("loada_daddr", d_addr, 8'h01);
    chk("loada_ens", ens(), 5'b00100);
    step();
    chk("loadb_state", state, 4'd4);
    chk("loadb_daddr", d_addr, 8'h01);
    chk("loadb_waddr", w_addr, 4'd3);
    chk("loadb_ens", ens(), 5'b00110);
    step();
    chk("load_done_state", state, 4'd1);
    chk("load_done_pc", pc, 7'd1);

    repeat (2) step();
    chk("add_state", state, 4'd6);
    chk("add_regs", {ra, rb, w_addr}, 12'h125);
    chk("add_alu", alu_s, 3'd1);
    chk("add_ens", ens(), 5'b00010);
    step();
    chk("add_done_ens", ens(), 5'b10000);

    repeat (2) step();
    chk("sub_state", state, 4'd7);
    chk("sub_regs", {ra, rb, w_addr}, 12'h426);
    chk("sub_alu", alu_s, 3'd2);
    chk("sub_ens", ens(), 5'b00010);

    repeat (3) step();
    chk("store_state", state, 4'd5);
    chk("store_daddr", d_addr, 8'h05);
    chk("store_ra", ra, 4'd5);
    chk("store_ens", ens(), 5'b01000);
    step();
    chk("store_done_ens", ens(), 5'b10000);

    repeat (2) step();
    chk("noop_state", state, 4'd8);
    chk("noop_ir", ir, 16'hF000);
    chk("noop_ens", ens(), 5'b00000);

    repeat (3) step();
    chk("halt_state", state, 4'd9);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("halt_hold", {state, 1'b0, pc, ens()}, {4'd9, 1'b0, 7'd6, 5'b00001});
    end
    chk("halt_ir", ir, 16'h5000);

    // Abort a LOAD mid-LOAD_B
    rst_n = 1'b0;
    #1 chk("halt_rst_ens", ens(), 5'b00000);
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("abort_pre_state", state, 4'd4);
    chk("abort_pre_ens", ens(), 5'b00110);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ens", ens(), 5'b00000);
    chk("abort_state", state, 4'd0);
    chk("abort_pc", pc, 7'd0);
    chk("abort_daddr", d_addr, 8'h00);

    // PC wrap on the PC_W=2 instance
    rst2_n = 1'b1;
    exp_pc = 2'd0;
    for (int k = 0; k < 5; k++) begin
      found = 1'b0;
      for (int n = 0; n < 10; n++) begin
        if (state2 == 4'd1) begin
          found = 1'b1;
          break;
        end
        step();
      end
      chk("wrap_fetch_seen", {31'd0, found}, 32'd1);
      chk("wrap_pc", pc2, exp_pc);
      exp_pc = exp_pc + 2'd1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
